// File: rtl/swap_mode_ctrl_pkg.sv
// ============================================================================
//  Module  : swap_mode_ctrl_pkg
//  Purpose : Mode encodings shared by the mode controller and swap filter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package swap_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RG   = 2'b00,
    MODE_GB   = 2'b01,
    MODE_RB   = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  // Step order seen by the user: pass -> RG -> RB -> GB -> pass
  function automatic mode_e nextMode(input mode_e m);
    case (m)
      MODE_PASS: nextMode = MODE_RG;
      MODE_RG:   nextMode = MODE_RB;
      MODE_RB:   nextMode = MODE_GB;
      default:   nextMode = MODE_PASS;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/swap_mode_ctrl_key_debounce.sv
// ============================================================================
//  Module  : key_debounce
//  Purpose : Two-flop synchronizer, stability counter and press pulse for one key.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic keyRaw,
  output logic press
);

  localparam logic [CNT_W-1:0] c_cntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_deb   <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= keyRaw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cntLast) begin
        r_deb   <= r_sync2;
        r_cnt   <= '0;
        r_press <= r_deb & ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/swap_mode_ctrl.sv
// ============================================================================
//  Module  : swap_mode_ctrl
//  Purpose : Key-driven colour-swap mode, committed only at vertical sync start.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module swap_mode_ctrl
  import swap_mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int CNT_W           = 19
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [1:0] iKEY,
  input  logic       iVS_N,
  output logic [1:0] oMode,
  output logic       oPending,
  output logic [1:0] oPress
);

  logic [1:0] w_press;
  mode_e      r_mode;
  mode_e      r_pending;
  logic       r_pendFlag;
  logic       r_vsPrev;
  mode_e      w_pendNext;
  mode_e      w_modeNext;
  logic       w_vsFall;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk    (iCLK),
      .rst_n  (iRST_N),
      .keyRaw (iKEY[k]),
      .press  (w_press[k])
    );
  end

  assign w_vsFall = r_vsPrev & ~iVS_N;

  // Commit samples the pending value from before any same-cycle press
  always_comb begin
    w_pendNext = r_pending;
    if (w_press[1])
      w_pendNext = MODE_PASS;
    else if (w_press[0])
      w_pendNext = nextMode(r_pending);
    w_modeNext = w_vsFall ? r_pending : r_mode;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_mode     <= MODE_PASS;
      r_pending  <= MODE_PASS;
      r_pendFlag <= 1'b0;
      r_vsPrev   <= 1'b1;
    end else begin
      r_vsPrev   <= iVS_N;
      r_pending  <= w_pendNext;
      r_mode     <= w_modeNext;
      r_pendFlag <= (w_pendNext != w_modeNext);
    end
  end

  assign oMode    = r_mode;
  assign oPending = r_pendFlag;
  assign oPress   = w_press;

endmodule

`default_nettype wire
